seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 121 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - run-controlled 4-bit serial pattern detector with match counting
module seq_det_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_pattern,
    input  logic             cfg_ovp,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in,
    input  logic             in_valid,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pattern_q, pattern_d;
    logic             ovp_q, ovp_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [2:0]       hist_q, hist_d;
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             match;

    // Abort suppresses a match landing on the same cycle.
    assign match = (state_q == S_RUN) && in_valid && !abort && (fill_q == 2'd3)
                   && ({hist_q, in} == pattern_q);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        ovp_d     = ovp_q;
        target_d  = target_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        case (state_q)
            S_RUN: begin
                err_d = cfg_we;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    hist_d = {hist_q[1:0], in};
                    if (match) begin
                        fill_d = ovp_q ? 2'd3 : 2'd0;
                        cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                        if ((target_q != '0) && (cnt_d == target_q)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
                    end
                end
            end
            default: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    ovp_d     = cfg_ovp;
                    target_d  = cfg_target;
                end
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pattern_q <= 4'b1010;
            ovp_q     <= 1'b0;
            target_q  <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            ovp_q     <= ovp_d;
            target_q  <= target_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign out       = match;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed and random checks of seq_det_ctrl against a queue-based model
module tb_seq_det_ctrl;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_pattern = 4'd0;
    logic             cfg_ovp = 1'b0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in = 1'b0;
    logic             in_valid = 1'b0;
    logic             out, busy, done, cfg_err;
    logic [CNT_W-1:0] match_cnt;

    seq_det_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_ovp(cfg_ovp), .cfg_target(cfg_target), .start(start), .abort(abort),
        .in(in), .in_valid(in_valid), .out(out), .busy(busy), .done(done),
        .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 run, 2 done; hq holds valid bits since the last window restart.
    int       m_state;
    bit [3:0] m_pat;
    bit       m_ovp;
    int       m_tgt;
    int       m_cnt;
    bit       m_err;
    bit       hq[$];
    logic     last_out;
    int       outs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit model_out(bit i, bit v, bit ab);
        int n = hq.size();
        if (m_state != 1 || !v || ab || n < 3) return 1'b0;
        return {hq[n-3], hq[n-2], hq[n-1], i} == m_pat;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pat = 4'b1010; m_ovp = 0; m_tgt = 0; m_cnt = 0; m_err = 0;
        hq.delete();
    endtask

    task automatic model_step(bit we, bit [3:0] pat, bit ovp, int tgt, bit st, bit ab, bit i, bit v);
        bit mt = model_out(i, v, ab);
        m_err = 0;
        if (m_state != 1) begin
            if (we) begin m_pat = pat; m_ovp = ovp; m_tgt = tgt; end
            if (st) begin m_state = 1; m_cnt = 0; hq.delete(); end
        end else begin
            m_err = we;
            if (ab) m_state = 0;
            else if (v) begin
                hq.push_back(i);
                if (hq.size() > 3) void'(hq.pop_front());
                if (mt) begin
                    if (m_cnt < CMAX) m_cnt++;
                    if (!m_ovp) hq.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
                end
            end
        end
    endtask

    task automatic step(bit we, bit [3:0] pat, bit ovp, int tgt, bit st, bit ab, bit i, bit v);
        @(negedge clk);
        cfg_we = we; cfg_pattern = pat; cfg_ovp = ovp; cfg_target = tgt[CNT_W-1:0];
        start = st; abort = ab; in = i; in_valid = v;
        #1;
        last_out = out;
        if (out === 1'b1) outs++;
        chk("out", out, model_out(i, v, ab));
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
        chk("match_cnt", match_cnt, m_cnt);
        chk("cfg_err", cfg_err, m_err);
        model_step(we, pat, ovp, tgt, st, ab, i, v);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();           step(0, 4'd0, 0, 0, 0, 0, 0, 0); endtask
    task automatic go();             step(0, 4'd0, 0, 0, 1, 0, 0, 0); endtask
    task automatic stop();           step(0, 4'd0, 0, 0, 0, 1, 0, 0); endtask
    task automatic bit_in(bit b);    step(0, 4'd0, 0, 0, 0, 0, b, 1); endtask
    task automatic cfg(bit [3:0] p, bit o, int t); step(1, p, o, t, 0, 0, 0, 0); endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_err", cfg_err, 0);
        model_reset();
        cfg_we = 0; start = 0; abort = 0; in = 0; in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Default pattern 1010, non-overlapping.
        go();
        for (int k = 1; k <= 10; k++) begin
            bit_in(k % 2);
            chk("nov_out", last_out, (k == 4 || k == 8));
        end
        chk("nov_cnt", match_cnt, 2);
        chk("nov_busy", busy, 1);
        stop();

        cfg(4'b1010, 1, 0);
        go();
        for (int k = 1; k <= 10; k++) begin
            bit_in(k % 2);
            chk("ovp_out", last_out, (k >= 4 && k % 2 == 0));
        end
        chk("ovp_cnt", match_cnt, 4);
        stop();

        cfg(4'b1010, 1, 3);
        go();
        for (int k = 1; k <= 10; k++) begin
            bit_in(k % 2);
            chk("tgt_out", last_out, (k == 4 || k == 6 || k == 8));
            if (k == 8) chk("tgt_done", done, 1);
        end
        chk("tgt_cnt", match_cnt, 3);
        go();
        chk("tgt_clr", match_cnt, 0);

        // Config write during a run is rejected.
        step(1, 4'b1100, 0, 0, 0, 0, 0, 0);
        chk("lock_err", cfg_err, 1);
        idle();
        chk("lock_err_end", cfg_err, 0);
        outs = 0;
        bit_in(1); bit_in(1); bit_in(0); bit_in(0);
        chk("lock_nomatch", outs, 0);
        stop();
        cfg(4'b1100, 0, 0);
        go();
        outs = 0;
        bit_in(1); bit_in(1); bit_in(0); bit_in(0);
        chk("cfg_match", last_out, 1);
        chk("cfg_outs", outs, 1);
        stop();

        cfg(4'b1010, 0, 0);
        go();
        bit_in(1); bit_in(0); bit_in(1);
        step(0, 4'd0, 0, 0, 0, 1, 0, 1);
        chk("abort_out", last_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", match_cnt, 0);
        go();
        outs = 0;
        bit_in(1); idle(); bit_in(0); idle(); idle(); bit_in(1); idle(); bit_in(0);
        chk("gap_outs", outs, 1);

        // Reset while a match is pending on the live input.
        go();
        bit_in(1); bit_in(0); bit_in(1);
        @(negedge clk);
        in = 0; in_valid = 1;
        #1;
        chk("pre_rst_out", out, 1);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            bit we = ($urandom_range(0, 14) == 0);
            bit st = ($urandom_range(0, 24) == 0);
            bit ab = ($urandom_range(0, 59) == 0);
            bit v  = ($urandom_range(0, 3) != 0);
            bit [3:0] p = 4'($urandom_range(0, 15));
            step(we, p, 1'($urandom_range(0, 1)), $urandom_range(0, CMAX),
                 st, ab, 1'($urandom_range(0, 1)), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
